// File: rtl/exec_unit.sv
// exec_unit: execute stage holding the register file, the operand-2 mux,
// a single-cycle ALU and an iterative shift-add multiplier with a
// valid/ready handshake so the control unit can stall while MUL runs.
module exec_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int CTRL_WIDTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDRESS_WIDTH-1:0] AD1,
  input  logic [ADDRESS_WIDTH-1:0] AD2,
  input  logic [ADDRESS_WIDTH-1:0] AD3,
  input  logic [DATA_WIDTH-1:0]    ImmOp,
  input  logic                     RegWrite,
  input  logic [CTRL_WIDTH-1:0]    ALUctrl,
  input  logic                     ALUsrc,
  output logic                     EQ,
  output logic                     LT,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    a0
);

  localparam int NREG  = 1 << ADDRESS_WIDTH;
  localparam int SHW   = $clog2(DATA_WIDTH);
  localparam int A0_IX = 10;

  localparam logic [CTRL_WIDTH-1:0] OP_ADD  = CTRL_WIDTH'(0);
  localparam logic [CTRL_WIDTH-1:0] OP_SUB  = CTRL_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] OP_AND  = CTRL_WIDTH'(2);
  localparam logic [CTRL_WIDTH-1:0] OP_OR   = CTRL_WIDTH'(3);
  localparam logic [CTRL_WIDTH-1:0] OP_XOR  = CTRL_WIDTH'(4);
  localparam logic [CTRL_WIDTH-1:0] OP_SLL  = CTRL_WIDTH'(5);
  localparam logic [CTRL_WIDTH-1:0] OP_SRL  = CTRL_WIDTH'(6);
  localparam logic [CTRL_WIDTH-1:0] OP_SRA  = CTRL_WIDTH'(7);
  localparam logic [CTRL_WIDTH-1:0] OP_SLT  = CTRL_WIDTH'(8);
  localparam logic [CTRL_WIDTH-1:0] OP_SLTU = CTRL_WIDTH'(9);
  localparam logic [CTRL_WIDTH-1:0] OP_MUL  = CTRL_WIDTH'(10);

  typedef enum logic {IDLE, MUL} state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   regs [NREG];
  logic [DATA_WIDTH-1:0]   rd1, rd2, op2, alu_result;
  logic [SHW-1:0]          shamt;
  logic                    accept, is_mul, mul_last;

  logic [DATA_WIDTH-1:0]    mcand_reg, mplier_reg, acc_reg, acc_next;
  logic [SHW-1:0]           cnt_reg;
  logic [ADDRESS_WIDTH-1:0] mrd_reg;
  logic                     mwe_reg;
  logic                     done_reg;

  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;

  // x0 always reads as zero regardless of storage contents
  assign rd1   = (AD1 == '0) ? '0 : regs[AD1];
  assign rd2   = (AD2 == '0) ? '0 : regs[AD2];
  assign op2   = ALUsrc ? ImmOp : rd2;
  assign shamt = op2[SHW-1:0];

  assign EQ       = (rd1 == op2);
  assign LT       = ($signed(rd1) < $signed(op2));
  assign in_ready = (state_reg == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (ALUctrl == OP_MUL);
  assign mul_last = (state_reg == MUL) && (cnt_reg == '0);
  assign acc_next = mplier_reg[0] ? acc_reg + mcand_reg : acc_reg;
  assign done     = done_reg;
  assign a0       = regs[A0_IX];

  // single-cycle ALU; unused encodings yield zero
  always_comb begin
    alu_result = '0;
    case (ALUctrl)
      OP_ADD:  alu_result = rd1 + op2;
      OP_SUB:  alu_result = rd1 - op2;
      OP_AND:  alu_result = rd1 & op2;
      OP_OR:   alu_result = rd1 | op2;
      OP_XOR:  alu_result = rd1 ^ op2;
      OP_SLL:  alu_result = rd1 << shamt;
      OP_SRL:  alu_result = rd1 >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(rd1) >>> shamt);
      OP_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, LT};
      OP_SLTU: alu_result = {{(DATA_WIDTH-1){1'b0}}, (rd1 < op2)};
      default: alu_result = '0;
    endcase
  end

  // single write port: a completing MUL and a new single-cycle op never coincide
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = AD3;
    wr_data = alu_result;
    if (accept && !is_mul) begin
      wr_en = RegWrite && (AD3 != '0);
    end else if (mul_last) begin
      wr_en   = mwe_reg && (mrd_reg != '0);
      wr_addr = mrd_reg;
      wr_data = acc_next;
    end
  end

  // one storage register per architectural register, cleared by reset
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          regs[gi] <= '0;
        else if (wr_en && (wr_addr == ADDRESS_WIDTH'(gi)))
          regs[gi] <= wr_data;
      end
    end
  endgenerate

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // next-state logic: stay in MUL until the counter runs out
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && is_mul) state_next = MUL;
      MUL:     if (cnt_reg == '0)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // multiplier datapath: capture on accept, then one shift-add step per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      mrd_reg    <= '0;
      mwe_reg    <= 1'b0;
    end else if (accept && is_mul) begin
      mcand_reg  <= rd1;
      mplier_reg <= op2;
      acc_reg    <= '0;
      cnt_reg    <= SHW'(DATA_WIDTH - 1);
      mrd_reg    <= AD3;
      mwe_reg    <= RegWrite;
    end else if (state_reg == MUL) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg - 1'b1;
    end
  end

  // completion pulse, one cycle after the writing edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_reg <= 1'b0;
    else     done_reg <= (accept && !is_mul) || mul_last;
  end

endmodule
